// File: rtl/turf_rdwr_pkg.sv
// Shared definitions for the TURF read/write decoder: FSM states, port geometry
// and the default read data returned when a port never answers.
package turf_rdwr_pkg;

  localparam int NPORTS = 4;
  localparam int PORT_W = $clog2(NPORTS);
  localparam int PORT_SEL_LSB = 26;
  localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  function automatic logic [NPORTS-1:0] port_onehot(input logic [PORT_W-1:0] port);
    logic [NPORTS-1:0] oh;
    oh = '0;
    oh[port] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/turf_rdwr_timer.sv
// Per-access cycle counter: held at zero while idle, counts while run is high,
// and flags the cycle in which the port has had TIMEOUT cycles to answer.
module turf_rdwr_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic aclk,
  input  logic areset,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // Dropping run between accesses is what clears the count for the next entry.
  always_comb begin
    count_d = '0;
    if (run) count_d = count_q + 1'b1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign expired = run && (count_q == LAST);

endmodule

// File: rtl/turf_rdwr_decode.sv
// Decodes a 28-bit upstream access into one of four downstream ports, waits for
// that port's ack (or a forced timeout), then returns a single-cycle ack upstream.
module turf_rdwr_decode
  import turf_rdwr_pkg::*;
#(
  parameter int          TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = DEFAULT_TIMEOUT_DATA
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                en_i,
  input  logic                wr_i,
  input  logic [27:0]         adr_i,
  input  logic [31:0]         dat_i,
  output logic                ack_o,
  output logic [31:0]         dat_o,
  output logic [NPORTS-1:0]   m_en_o,
  output logic                m_wr_o,
  output logic [25:0]         m_adr_o,
  output logic [31:0]         m_dat_o,
  input  logic [NPORTS-1:0]   m_ack_i,
  input  logic [32*NPORTS-1:0] m_dat_i,
  output logic                timeout_o,
  output logic [15:0]         timeout_count_o
);

  state_e state_q, state_d;

  logic [PORT_W-1:0] port_q, port_d;
  logic              m_wr_q, m_wr_d;
  logic [25:0]       m_adr_q, m_adr_d;
  logic [31:0]       m_dat_q, m_dat_d;
  logic [31:0]       dat_q, dat_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       timeout_count_q, timeout_count_d;

  logic        timer_expired;
  logic        port_ack;
  logic [31:0] port_rdata;

  assign port_ack   = (state_q == ACTIVE) && m_ack_i[port_q];
  assign port_rdata = m_dat_i[{port_q, 5'd0} +: 32];

  turf_rdwr_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .aclk    (aclk),
    .areset  (areset),
    .run     (state_q == ACTIVE),
    .expired (timer_expired)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // en_i is deliberately ignored in RESPOND; upstream only drops it afterwards.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i) state_d = ACTIVE;
      ACTIVE:  if (port_ack || timer_expired) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_en_o = '0;
    ack_o  = 1'b0;
    case (state_q)
      ACTIVE:  m_en_o = port_onehot(port_q);
      RESPOND: ack_o  = 1'b1;
      default: ;
    endcase
  end

  // A port ack in the expiry cycle takes priority over the forced response.
  always_comb begin
    port_d          = port_q;
    m_wr_d          = m_wr_q;
    m_adr_d         = m_adr_q;
    m_dat_d         = m_dat_q;
    dat_d           = dat_q;
    timeout_d       = 1'b0;
    timeout_count_d = timeout_count_q;
    if (state_q == IDLE && en_i) begin
      port_d  = adr_i[PORT_SEL_LSB +: PORT_W];
      m_adr_d = adr_i[PORT_SEL_LSB-1:0];
      m_wr_d  = wr_i;
      m_dat_d = dat_i;
    end else if (port_ack) begin
      if (!m_wr_q) dat_d = port_rdata;
    end else if (timer_expired) begin
      if (!m_wr_q) dat_d = TIMEOUT_DATA;
      timeout_d = 1'b1;
      if (timeout_count_q != 16'hFFFF) timeout_count_d = timeout_count_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      port_q          <= '0;
      m_wr_q          <= 1'b0;
      m_adr_q         <= '0;
      m_dat_q         <= '0;
      dat_q           <= '0;
      timeout_q       <= 1'b0;
      timeout_count_q <= '0;
    end else begin
      port_q          <= port_d;
      m_wr_q          <= m_wr_d;
      m_adr_q         <= m_adr_d;
      m_dat_q         <= m_dat_d;
      dat_q           <= dat_d;
      timeout_q       <= timeout_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign m_wr_o          = m_wr_q;
  assign m_adr_o         = m_adr_q;
  assign m_dat_o         = m_dat_q;
  assign dat_o           = dat_q;
  assign timeout_o       = timeout_q;
  assign timeout_count_o = timeout_count_q;

endmodule
